// File: rtl/eb_pkg.sv
// Definitions shared by the write- and read-side elastic buffer controllers:
// default ordered-set symbols, FSM state type and Gray/binary pointer conversion.
package eb_pkg;

    localparam logic [9:0] EB_COMMA_SYMBOL = 10'h1BC;
    localparam logic [9:0] EB_SKIP_SYMBOL  = 10'h1A1;

    typedef enum logic [0:0] {
        WAIT_COMMA = 1'b0,
        COMMA_SEEN = 1'b1
    } eb_state_e;

    // Operates on zero-extended 32-bit values so any pointer width up to 32 can use it.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin = 32'd0;
        for (int i = 0; i < 32; i++) begin
            bin[i] = ^(gray >> i);
        end
        return bin;
    endfunction

endpackage

// File: rtl/eb_write_controller.sv
// Recovered-clock write side of the receive elastic buffer: writes symbols into the
// buffer RAM, drops surplus SKIPs inside ordered sets, and tracks occupancy/overflow.
module eb_write_controller
    import eb_pkg::*;
#(
    parameter int                        ADDRESS_WIDTH    = 4,
    parameter int                        DATA_WIDTH       = 10,
    parameter logic [DATA_WIDTH-1:0]     COMMA_SYMBOL     = DATA_WIDTH'(EB_COMMA_SYMBOL),
    parameter logic [DATA_WIDTH-1:0]     SKIP_SYMBOL      = DATA_WIDTH'(EB_SKIP_SYMBOL),
    parameter int                        REMOVE_THRESHOLD = 10,
    parameter int                        MAX_SKIP_REMOVE  = 2
) (
    input  logic                         recovered_clock,
    input  logic                         recovered_reset,
    input  logic                         data_valid,
    input  logic [DATA_WIDTH-1:0]        data_in,
    input  logic [ADDRESS_WIDTH:0]       read_pointer_gray_sync,
    input  logic                         clear_status,
    output logic                         write_enable,
    output logic [ADDRESS_WIDTH-1:0]     write_address,
    output logic [DATA_WIDTH-1:0]        write_data,
    output logic [ADDRESS_WIDTH:0]       write_pointer_gray,
    output logic [ADDRESS_WIDTH:0]       fill_level,
    output logic                         skip_removed,
    output logic [7:0]                   removed_count,
    output logic                         overflow
);

    localparam int                 PW      = ADDRESS_WIDTH + 1;
    localparam int                 DROPS_W = $clog2(MAX_SKIP_REMOVE + 1);
    localparam logic [PW-1:0]      DEPTH_P = {1'b1, {ADDRESS_WIDTH{1'b0}}};

    eb_state_e                 state_q, state_d;
    logic [DROPS_W-1:0]        drops_q, drops_d;
    logic [PW-1:0]             wp_q, wp_d;
    logic                      overflow_q, overflow_d;
    logic [7:0]                removed_count_q, removed_count_d;
    logic                      write_enable_q;
    logic [ADDRESS_WIDTH-1:0]  write_address_q;
    logic [DATA_WIDTH-1:0]     write_data_q;
    logic [PW-1:0]             wp_gray_q;
    logic [PW-1:0]             fill_level_q;
    logic                      skip_removed_q;

    logic [PW-1:0]             rp_s;
    logic [PW-1:0]             occ_s;
    logic                      full_s;
    logic                      is_comma_s;
    logic                      is_skip_s;
    logic                      remove_s;
    logic                      write_s;
    logic                      lost_s;

    // Occupancy, per-symbol action (remove/lose/write) and next-state for FSM and status.
    always_comb begin
        rp_s       = PW'(gray2bin(32'(read_pointer_gray_sync)));
        occ_s      = wp_q - rp_s;
        full_s     = (occ_s == DEPTH_P);
        is_comma_s = (data_in == COMMA_SYMBOL);
        is_skip_s  = (data_in == SKIP_SYMBOL);
        remove_s   = data_valid && (state_q == COMMA_SEEN) && is_skip_s
                     && (32'(occ_s) >= 32'(REMOVE_THRESHOLD))
                     && (32'(drops_q) < 32'(MAX_SKIP_REMOVE));
        write_s    = data_valid && !remove_s && !full_s;
        lost_s     = data_valid && !remove_s && full_s;

        state_d = state_q;
        drops_d = drops_q;
        if (data_valid) begin
            case (state_q)
                WAIT_COMMA: begin
                    if (is_comma_s) begin
                        state_d = COMMA_SEEN;
                        drops_d = DROPS_W'(0);
                    end else begin
                        state_d = WAIT_COMMA;
                    end
                end
                COMMA_SEEN: begin
                    if (is_comma_s) begin
                        drops_d = DROPS_W'(0);
                    end else if (is_skip_s) begin
                        if (remove_s) begin
                            drops_d = drops_q + DROPS_W'(1);
                        end else begin
                            drops_d = drops_q;
                        end
                    end else begin
                        state_d = WAIT_COMMA;
                    end
                end
                default: begin
                    state_d = WAIT_COMMA;
                    drops_d = DROPS_W'(0);
                end
            endcase
        end else begin
            state_d = state_q;
        end

        if (write_s) begin
            wp_d = wp_q + PW'(1);
        end else begin
            wp_d = wp_q;
        end

        // A set in the same cycle as clear_status takes precedence over the clear.
        if (lost_s) begin
            overflow_d = 1'b1;
        end else if (clear_status) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end

        if (remove_s) begin
            if (clear_status) begin
                removed_count_d = 8'd1;
            end else if (removed_count_q == 8'hFF) begin
                removed_count_d = 8'hFF;
            end else begin
                removed_count_d = removed_count_q + 8'd1;
            end
        end else if (clear_status) begin
            removed_count_d = 8'd0;
        end else begin
            removed_count_d = removed_count_q;
        end
    end

    // State, pointer, status and registered RAM-port outputs.
    always_ff @(posedge recovered_clock or negedge recovered_reset) begin
        if (!recovered_reset) begin
            state_q         <= WAIT_COMMA;
            drops_q         <= DROPS_W'(0);
            wp_q            <= PW'(0);
            overflow_q      <= 1'b0;
            removed_count_q <= 8'd0;
            write_enable_q  <= 1'b0;
            write_address_q <= ADDRESS_WIDTH'(0);
            write_data_q    <= DATA_WIDTH'(0);
            wp_gray_q       <= PW'(0);
            fill_level_q    <= PW'(0);
            skip_removed_q  <= 1'b0;
        end else begin
            state_q         <= state_d;
            drops_q         <= drops_d;
            wp_q            <= wp_d;
            overflow_q      <= overflow_d;
            removed_count_q <= removed_count_d;
            write_enable_q  <= write_s;
            skip_removed_q  <= remove_s;
            wp_gray_q       <= PW'(bin2gray(32'(wp_d)));
            fill_level_q    <= occ_s;
            if (write_s) begin
                write_address_q <= wp_q[ADDRESS_WIDTH-1:0];
                write_data_q    <= data_in;
            end else begin
                write_address_q <= write_address_q;
                write_data_q    <= write_data_q;
            end
        end
    end

    assign write_enable       = write_enable_q;
    assign write_address      = write_address_q;
    assign write_data         = write_data_q;
    assign write_pointer_gray = wp_gray_q;
    assign fill_level         = fill_level_q;
    assign skip_removed       = skip_removed_q;
    assign removed_count      = removed_count_q;
    assign overflow           = overflow_q;

endmodule

// File: tb/tb_eb_write_controller.sv
// Directed and randomized bench for eb_write_controller against an integer-level
// model of buffer occupancy, ordered-set SKIP removal and sticky status.
module tb_eb_write_controller;

    localparam logic [9:0] COMMA = 10'h1BC;
    localparam logic [9:0] SKIP  = 10'h1A1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       data_valid;
    logic [9:0] data_in;
    logic [4:0] rp_gray;
    logic       clear_status;
    logic       write_enable;
    logic [3:0] write_address;
    logic [9:0] write_data;
    logic [4:0] write_pointer_gray;
    logic [4:0] fill_level;
    logic       skip_removed;
    logic [7:0] removed_count;
    logic       overflow;

    always #5 clk = ~clk;

    eb_write_controller #(
        .ADDRESS_WIDTH   (4),
        .DATA_WIDTH      (10),
        .COMMA_SYMBOL    (COMMA),
        .SKIP_SYMBOL     (SKIP),
        .REMOVE_THRESHOLD(10),
        .MAX_SKIP_REMOVE (2)
    ) dut (
        .recovered_clock       (clk),
        .recovered_reset       (rst_n),
        .data_valid            (data_valid),
        .data_in               (data_in),
        .read_pointer_gray_sync(rp_gray),
        .clear_status          (clear_status),
        .write_enable          (write_enable),
        .write_address         (write_address),
        .write_data            (write_data),
        .write_pointer_gray    (write_pointer_gray),
        .fill_level            (fill_level),
        .skip_removed          (skip_removed),
        .removed_count         (removed_count),
        .overflow              (overflow)
    );

    int checks   = 0;
    int failures = 0;

    // reference model state: pointers as plain integers modulo 32
    int m_wp, m_drops, m_cnt;
    bit m_inset, m_ovf;
    int we_seen, skip_seen;
    logic [4:0] prev_gray;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] rnd_data();
        logic [9:0] d;
        d = 10'($urandom);
        if (d == COMMA || d == SKIP) d = 10'h000;
        return d;
    endfunction

    task automatic model_reset();
        m_wp = 0; m_drops = 0; m_cnt = 0; m_inset = 1'b0; m_ovf = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_we"},   write_enable, 0);
        chk({tag, "_addr"}, write_address, 0);
        chk({tag, "_data"}, write_data, 0);
        chk({tag, "_gray"}, write_pointer_gray, 0);
        chk({tag, "_fill"}, fill_level, 0);
        chk({tag, "_skip"}, skip_removed, 0);
        chk({tag, "_cnt"},  removed_count, 0);
        chk({tag, "_ovf"},  overflow, 0);
    endtask

    // Reset is asserted between edges; outputs must drop immediately.
    task automatic do_reset();
        rst_n = 1'b0;
        data_valid = 1'b0; data_in = 10'h000; rp_gray = 5'd0; clear_status = 1'b0;
        #1;
        check_all_zero("reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input bit v, input logic [9:0] d, input int rp, input bit clr);
        int occ;
        bit rem, full, wr;
        int exp_addr;
        data_valid   = v;
        data_in      = d;
        rp_gray      = 5'((rp ^ (rp >> 1)) & 31);
        clear_status = clr;
        occ      = (m_wp - rp) & 31;
        rem      = v && m_inset && (d == SKIP) && (occ >= 10) && (m_drops < 2);
        full     = (occ == 16);
        wr       = v && !rem && !full;
        exp_addr = m_wp % 16;
        if (v) begin
            if (d == COMMA) begin
                m_inset = 1'b1; m_drops = 0;
            end else if (m_inset && d == SKIP) begin
                if (rem) m_drops++;
            end else begin
                m_inset = 1'b0;
            end
        end
        if (rem) m_cnt = clr ? 1 : ((m_cnt == 255) ? 255 : m_cnt + 1);
        else if (clr) m_cnt = 0;
        if (v && !rem && full) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (wr) m_wp = (m_wp + 1) & 31;
        @(posedge clk);
        #1;
        chk("write_enable", write_enable, wr);
        if (wr) begin
            chk("write_address", write_address, exp_addr);
            chk("write_data", write_data, d);
        end
        chk("skip_removed", skip_removed, rem);
        chk("removed_count", removed_count, m_cnt);
        chk("overflow", overflow, m_ovf);
        chk("write_pointer_gray", write_pointer_gray, (m_wp ^ (m_wp >> 1)));
        chk("fill_level", fill_level, occ);
        if (write_enable) we_seen++;
        if (skip_removed) skip_seen++;
    endtask

    initial begin
        rst_n = 1'b0;
        data_valid = 1'b0; data_in = 10'h000; rp_gray = 5'd0; clear_status = 1'b0;
        model_reset();
        #12;

        // overflow with read pointer parked at 0
        do_reset();
        we_seen = 0;
        for (int i = 0; i < 20; i++) step(1'b1, rnd_data(), 0, 1'b0);
        chk("ovf_write_count", we_seen, 16);
        chk("ovf_gray", write_pointer_gray, 5'b11000);
        chk("ovf_fill", fill_level, 16);
        chk("ovf_flag", overflow, 1);
        step(1'b0, 10'h000, 0, 1'b0);
        chk("ovf_sticky", overflow, 1);

        // removal at threshold
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, rnd_data(), 0, 1'b0);
        we_seen = 0; skip_seen = 0;
        step(1'b1, COMMA, 0, 1'b0);
        step(1'b1, SKIP, 0, 1'b0);
        step(1'b1, SKIP, 0, 1'b0);
        step(1'b1, SKIP, 0, 1'b0);
        step(1'b1, rnd_data(), 0, 1'b0);
        chk("rm_skip_pulses", skip_seen, 2);
        chk("rm_writes", we_seen, 3);
        chk("rm_count", removed_count, 2);

        // below threshold: occupancy held at 9 when the SKIP arrives
        do_reset();
        for (int i = 0; i < 9; i++) step(1'b1, rnd_data(), 0, 1'b0);
        skip_seen = 0; we_seen = 0;
        step(1'b1, COMMA, 0, 1'b0);
        step(1'b1, SKIP, 1, 1'b0);
        chk("below_skip_pulses", skip_seen, 0);
        chk("below_writes", we_seen, 2);

        // wrap-around with read pointer trailing by three
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, rnd_data(), 0, 1'b0);
        for (int i = 0; i < 70; i++) begin
            logic [4:0] g;
            prev_gray = write_pointer_gray;
            step(1'b1, 10'($urandom), (m_wp - 3) & 31, 1'b0);
            g = prev_gray ^ write_pointer_gray;
            chk("gray_one_bit", $countones(g), 1);
        end
        chk("wrap_fill", fill_level, 3);
        chk("wrap_no_ovf", overflow, 0);

        // clear colliding with a full-drop, then a lone clear
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b1, rnd_data(), 0, 1'b0);
        step(1'b1, rnd_data(), 0, 1'b1);
        chk("clr_collide_ovf", overflow, 1);
        step(1'b0, 10'h000, 0, 1'b1);
        chk("clr_lone_ovf", overflow, 0);
        chk("clr_lone_cnt", removed_count, 0);

        // reset in the middle of an ordered set
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, rnd_data(), 0, 1'b0);
        step(1'b1, COMMA, 0, 1'b0);
        step(1'b1, SKIP, 0, 1'b0);
        chk("midset_removed", skip_removed, 1);
        #2;
        do_reset();
        step(1'b1, SKIP, 0, 1'b0);
        chk("post_reset_skip_written", write_enable, 1);
        chk("post_reset_no_remove", skip_removed, 0);

        // randomized traffic biased toward high occupancy
        do_reset();
        for (int i = 0; i < 400; i++) begin
            bit v, clr;
            logic [9:0] d;
            int rp;
            v   = ($urandom % 4) != 0;
            clr = ($urandom % 16) == 0;
            case ($urandom % 4)
                0:       d = COMMA;
                1, 2:    d = SKIP;
                default: d = rnd_data();
            endcase
            rp = (m_wp - int'($urandom_range(6, 16))) & 31;
            step(v, d, rp, clr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/eb_write_controller.md
# eb_write_controller

Write-side controller for the receive elastic buffer, running in the recovered-clock domain. It is the parametrised successor of the existing write block. It generalises symbol width, buffer depth, removal threshold and the number of SKIP symbols removed per ordered set. It drives the buffer RAM write port directly, exchanges Gray-coded pointers with the read side, and reports fill level, removal statistics and a sticky overflow.

## Interface
- `ADDRESS_WIDTH`, 4: RAM address bits. Depth is 2^ADDRESS_WIDTH; pointers are ADDRESS_WIDTH+1 bits.
- `DATA_WIDTH`, 10: symbol width.
- `COMMA_SYMBOL`, 10'h1BC: ordered-set start symbol.
- `SKIP_SYMBOL`, 10'h1A1: removable symbol.
- `REMOVE_THRESHOLD`, 10: minimum fill level at which a SKIP may be removed.
- `MAX_SKIP_REMOVE`, 2: maximum SKIPs removed per ordered set (≥1).

Ports:
- `recovered_clock`  in  1  sole clock.
- `recovered_reset`  in  1  asynchronous, active-low reset.
- `data_valid`  in  1  `data_in` is valid this cycle.
- `data_in`  in  DATA_WIDTH  received symbol.
- `read_pointer_gray_sync`  in  ADDRESS_WIDTH+1  read pointer, Gray-coded, already synchronised into this domain.
- `clear_status`  in  1  clears `overflow` and `removed_count`.
- `write_enable`  out  1  RAM write strobe.
- `write_address`  out  ADDRESS_WIDTH  RAM address.
- `write_data`  out  DATA_WIDTH  RAM data.
- `write_pointer_gray`  out  ADDRESS_WIDTH+1  write pointer, Gray-coded, for the read side.
- `fill_level`  out  ADDRESS_WIDTH+1  occupancy, 0..2^ADDRESS_WIDTH.
- `skip_removed`  out  1  a SKIP was dropped this cycle.
- `removed_count`  out  8  saturating count of removed SKIPs.
- `overflow`  out  1  sticky: a symbol was lost because the buffer was full.

## Operation
- **Internal pointer:** binary write pointer `wp`, ADDRESS_WIDTH+1 bits.
- **Read pointer:** `rp` = gray2bin(`read_pointer_gray_sync`).
- **Occupancy:** `occ` = (`wp` − `rp`) mod 2^(ADDRESS_WIDTH+1), combinational. Full when `occ` == 2^ADDRESS_WIDTH.

FSM states: WAIT_COMMA, COMMA_SEEN. Per-set drop counter `drops`.
- **WAIT_COMMA:**
  - Valid COMMA → COMMA_SEEN, `drops`=0.
  - Anything else → stay.
- **COMMA_SEEN:**
  - Valid COMMA → stay, `drops`=0.
  - Valid SKIP → stay; the SKIP is removed if `occ` ≥ REMOVE_THRESHOLD and `drops` < MAX_SKIP_REMOVE.
  - Valid non-SKIP, non-COMMA → WAIT_COMMA.
- `data_valid`=0: FSM, `drops` and pointer hold; nothing is written.

Per valid cycle, exactly one of the following happens, in priority order:
1. **Remove:** no write, `wp` holds, `skip_removed`=1, `drops`+1, `removed_count`+1 (saturates at 255).
2. **Full:** no write, `wp` holds, `overflow` set.
3. **Write:** `write_enable`=1, `write_address`=`wp`[ADDRESS_WIDTH-1:0], `write_data`=`data_in`, `wp`+1 (wraps modulo 2^(ADDRESS_WIDTH+1)).

Status and boundary rules:
- Removal while full is legal and does not flag overflow.
- `clear_status` zeroes `overflow` and `removed_count`. A set or increment in the same cycle wins, leaving `overflow`=1 and `removed_count`=1.
- All outputs reset to 0 and the FSM resets to WAIT_COMMA, asynchronously, including mid ordered set. A SKIP after reset release, without a new COMMA, is written.

## Timing
- `write_enable`, `write_address`, `write_data`, `skip_removed` are registered: one cycle after the sampling edge of `data_in`.
- `write_pointer_gray` = bin2gray of the new `wp`, registered on the same edge as `wp`. Exactly one bit changes per increment.
- `fill_level` = registered `occ`, one cycle behind `wp`/`rp`. Decisions use the combinational `occ`, not `fill_level`.
- No handshake back-pressure: the input accepts one symbol per `data_valid` cycle unconditionally.

## Structure
- Shared package `eb_pkg`: `COMMA_SYMBOL`/`SKIP_SYMBOL` defaults, FSM state typedef, `bin2gray`/`gray2bin` functions (parametrised width), shared with the read-side controller.
- No sub-module is needed; the FSM, pointer, occupancy logic and status logic live in one module.

## Test plan
(ADDRESS_WIDTH=4, threshold 10, MAX_SKIP_REMOVE=2)
- **Overflow:** reset; 20 valid non-COMMA symbols, read pointer held at 0 → addresses 0..15 written; 17th symbol onward not written; `overflow`=1 and stays 1; `write_pointer_gray`=5'b11000; `fill_level`=16.
- **Removal:** `occ`=10; COMMA, SKIP, SKIP, SKIP, D → COMMA written; two SKIPs dropped (`skip_removed` high 2 cycles); third SKIP written; `removed_count`=2.
- **Below threshold:** `occ`=9; COMMA, SKIP → both written; `skip_removed` stays 0.
- **Wrap-around:** read pointer tracks `wp`−3; 70 symbols → `fill_level` constant at 3; address wraps 15→0; `write_pointer_gray` changes one bit per write; no overflow.
- **Clear collision:** `clear_status` in the same cycle as a full-drop → `overflow` stays 1. A later lone `clear_status` → `overflow`=0, `removed_count`=0.
- **Reset mid-set:** COMMA, SKIP removed, then `recovered_reset` low → all outputs 0 immediately. After release, a SKIP without a preceding COMMA is written.
